// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side bus bundle for the simulink2ppc snapshot register.
// Vectors keep the OPB big-endian numbering: index 0 is the most significant bit.
interface opb_register_simulink2ppc_snap_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;
    logic        Sl_xferAck;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
    );
endinterface

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PowerPC snapshot register: captures user words on a valid strobe and
// exposes the last word plus fresh/overrun/freeze/count status over OPB.
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010004FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32
) (
    input  logic                                   OPB_Clk,
    input  logic                                   OPB_Rst_n,
    opb_register_simulink2ppc_snap_if.slave        opb,
    input  logic [31:0]                            user_data_in,
    input  logic                                   user_data_valid
);

    if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32) begin : g_width_check
        $error("opb_register_simulink2ppc_snap supports only 32-bit OPB");
    end

    typedef enum logic [1:0] {StIdle, StAck, StGap} state_e;

    // Reset asserts asynchronously but is released on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    state_e      state_q, state_d;
    logic        wsel_q, rnw_q, be3_q, wclr_q, wfrz_q;
    logic [31:0] hold_q, hold_d;
    logic [15:0] count_q, count_d;
    logic        fresh_q, fresh_d;
    logic        overrun_q, overrun_d;
    logic        freeze_q, freeze_d;

    logic        in_window, hit, ack;
    logic        capture, data_rd_ack, status_wr;
    logic [31:0] status_word;

    assign in_window = (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);
    assign hit       = opb.OPB_select && in_window && (state_q == StIdle);
    assign ack       = (state_q == StAck);

    assign capture     = user_data_valid && !freeze_q;
    assign data_rd_ack = ack && rnw_q && !wsel_q;
    assign status_wr   = ack && !rnw_q && wsel_q && be3_q;
    assign status_word = {count_q, 13'b0, freeze_q, overrun_q, fresh_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (hit) state_d = StAck;
            StAck:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        hold_d    = hold_q;
        count_d   = count_q;
        fresh_d   = fresh_q;
        overrun_d = overrun_q;
        freeze_d  = freeze_q;

        if (capture) begin
            hold_d  = user_data_in;
            count_d = count_q + 16'd1;
        end

        // A capture always wins over the clear sources for fresh.
        if (capture) begin
            fresh_d = 1'b1;
        end else if ((status_wr && wclr_q) || data_rd_ack) begin
            fresh_d = 1'b0;
        end

        if (status_wr && wclr_q) begin
            overrun_d = 1'b0;
        end else if (capture && fresh_q && !data_rd_ack) begin
            overrun_d = 1'b1;
        end

        if (status_wr) begin
            freeze_d = wfrz_q;
        end
    end

    always_ff @(posedge OPB_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            wsel_q    <= 1'b0;
            rnw_q     <= 1'b0;
            be3_q     <= 1'b0;
            wclr_q    <= 1'b0;
            wfrz_q    <= 1'b0;
            hold_q    <= '0;
            count_q   <= '0;
            fresh_q   <= 1'b0;
            overrun_q <= 1'b0;
            freeze_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            fresh_q   <= fresh_d;
            overrun_q <= overrun_d;
            freeze_q  <= freeze_d;
            if (hit) begin
                wsel_q <= opb.OPB_ABus[29];
                rnw_q  <= opb.OPB_RNW;
                be3_q  <= opb.OPB_BE[3];
                wclr_q <= opb.OPB_DBus[31];
                wfrz_q <= opb.OPB_DBus[29];
            end
        end
    end

    // Data bus is ORed with other slaves, so it must be zero except on a read ack.
    always_comb begin
        opb.Sl_xferAck = ack;
        opb.Sl_DBus    = '0;
        if (ack && rnw_q) begin
            opb.Sl_DBus = wsel_q ? status_word : hold_q;
        end
    end

    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{opb.OPB_seqAddr, opb.OPB_DBus[0:28], opb.OPB_DBus[30],
                           opb.OPB_BE[0:2]};

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
Name: opb_register_simulink2ppc_snap

Overview:
- OPB slave register carrying data from fabric to software: user logic presents words with a valid strobe, and the PowerPC reads them over OPB.
- Holds the last captured word plus a status word with fresh and overrun flags, a capture counter and a freeze control.
- Acts as the read-back counterpart of the ppc2simulink software register. Sits on the same OPB segment at its own address window.

Parameters:
- C_BASEADDR, 32'h01000400, first byte address of the slave window.
- C_HIGHADDR, 32'h010004FF, last byte address of the slave window.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width. Only 32 is supported.

Ports:
- OPB_Clk  in  1  the only clock; OPB and user logic both run on it.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- Sl_DBus  out  [0:31]  read data. Sl_DBus[0] = register bit 31.
- Sl_errAck  out  1  tied 0.
- Sl_retry  out  1  tied 0.
- Sl_toutSup  out  1  tied 0.
- Sl_xferAck  out  1  transfer acknowledge.
- OPB_ABus  in  [0:31]  byte address. OPB_ABus[29] selects the word.
- OPB_BE  in  [0:3]  byte enables. OPB_BE[3] covers register bits 7:0.
- OPB_DBus  in  [0:31]  write data, same bit mapping as Sl_DBus.
- OPB_RNW  in  1  1 = read, 0 = write.
- OPB_select  in  1  slave select.
- OPB_seqAddr  in  1  ignored; every beat is handled as a single transfer.
- user_data_in  in  [31:0]  word from fabric.
- user_data_valid  in  1  capture strobe, one word per high cycle.

Behaviour:
- Reset (async assert, sync release):
  - Sl_DBus = 0, Sl_xferAck = 0.
  - hold = 0, count = 0, fresh = 0, overrun = 0, freeze = 0.
  - FSM = IDLE.
  - Asserting reset mid-transaction aborts it; no ack is issued.
- Hit condition: OPB_select = 1, C_BASEADDR <= OPB_ABus <= C_HIGHADDR, FSM in IDLE.
- Register map:
  - Offset 0x0 DATA: read returns hold. Writes are acked and ignored.
  - Offset 0x4 STATUS, read: bits[31:16] = count, bit 2 = freeze, bit 1 = overrun, bit 0 = fresh, all other bits 0.
  - Offset 0x4 STATUS, write: only takes effect when OPB_BE[3] = 1.
    - bit 0 = 1 clears fresh and overrun.
    - bit 2 loads freeze.
    - All other bits ignored.
- FSM:
  - IDLE -> ACK on a hit. Address, RNW, data and BE are registered on that edge.
  - ACK: lasts one cycle. Sl_xferAck = 1; for reads, Sl_DBus carries the value; write side effects commit at the end of this cycle. Then -> GAP.
  - GAP: one cycle, always -> IDLE. A hit in GAP is ignored, which gives the master time to deselect.
  - Latency: select in cycle n, ack in cycle n+1. Back-to-back beats complete at best every 3 cycles.
  - Outside ACK, Sl_DBus = 0 (OR-bus rule). Sl_DBus also stays 0 during write acks.
- Capture, evaluated every cycle with user_data_valid = 1 and freeze = 0:
  - hold <= user_data_in.
  - count <= count + 1, 16-bit, wraps 0xFFFF -> 0x0000.
  - fresh <= 1.
  - overrun <= 1 if fresh was already 1 and no DATA read is acked in this cycle.
  - While freeze = 1, valid is ignored completely: no hold, count or flag change.
- A DATA read ack clears fresh, unless a capture occurs in the same cycle.
- Simultaneous events:
  - DATA read ack + capture in the same cycle: the read returns the old hold; hold takes the new word; fresh = 1; overrun unchanged.
  - STATUS clear + capture in the same cycle: the capture wins for fresh (fresh = 1); overrun = 0.
  - STATUS read ack + capture in the same cycle: the read returns pre-capture values.
  - Writing freeze = 1 in the same cycle as a capture: that capture is still taken; freeze applies from the next cycle.
- Addresses inside the window are aliased; only OPB_ABus[29] is decoded.

Test Plan:
- Reset, then read 0x01000400 and 0x01000404 -> both acked in cycle n+1 with Sl_DBus = 0x00000000; errAck, retry and toutSup stay 0 throughout.
- Pulse valid with 0xDEADBEEF -> STATUS = 0x00010001. Read DATA -> 0xDEADBEEF. Read STATUS again -> 0x00010000.
- Two valid pulses (0x11, 0x22) with no read -> DATA = 0x00000022, STATUS = 0x00020003. Write 0x00000001 to STATUS with BE = 4'b1111 -> STATUS = 0x00020000. Repeat the write with BE = 4'b1110 -> no change.
- Write 0x00000004 to STATUS (freeze), pulse valid with 0x55 -> DATA and count unchanged, STATUS bit 2 = 1. Write 0x0 -> unfrozen; next valid is captured.
- Align a valid pulse (0xAA) with a DATA read ack while hold = 0x99 -> read returns 0x00000099, fresh = 1, overrun = 0. Separately, 65536 valid pulses -> count wraps to 0.
- Hold select high after an ack -> no second ack in GAP; the next ack arrives 3 cycles after the first. Assert OPB_Rst_n low in the ACK cycle -> ack drops immediately and all state is zeroed.
